tug_rope_ctrl: RTL and testbench

Game-core stage directly downstream of the per-player one-pulse generators. Consumes the single-cycle push pulses from the left player, right player and referee; tracks the rope position, detects round wins, and keeps per-player round scores until a match is won. Drives the rope LED bar and the score/winner outputs to the display logic.

---
 rtl/tug_rope_ctrl.sv | 100 ++++++++++
 tb/tb_tug_rope_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/tug_rope_ctrl.sv
// tug_rope_ctrl: tug-of-war game core tracking rope position, round wins and match scores
// ports: clk, rst (sync active-high); lpush/rpush/refpush single-cycle event pulses;
//        leds one-hot rope marker (bit POS_MAX+pos); lscore/rscore rounds won;
//        lwinrnd/rwinrnd one-cycle round-win pulses; playing/match_over state flags
module tug_rope_ctrl #(
    parameter int POS_MAX     = 4,
    parameter int WIN_ROUNDS  = 3,
    parameter int SCORE_W     = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lpush,
    input  logic                 rpush,
    input  logic                 refpush,
    output logic [2*POS_MAX:0]   leds,
    output logic [SCORE_W-1:0]   lscore,
    output logic [SCORE_W-1:0]   rscore,
    output logic                 lwinrnd,
    output logic                 rwinrnd,
    output logic                 playing,
    output logic                 match_over
);
    localparam int PW = $clog2(POS_MAX + 1) + 1;
    localparam int LW = 2 * POS_MAX + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic signed [PW-1:0] PMAX = PW'(POS_MAX);
    localparam logic [LW-1:0] CENTRE = LW'(1) << POS_MAX;
    typedef enum logic [1:0] {IDLE, PLAY, ROUND_END, MATCH_OVER} state_t;
    state_t state;
    logic signed [PW-1:0] pos, npos;
    logic [HW-1:0] hold;
    function automatic logic [LW-1:0] marker(input logic signed [PW-1:0] p);
        return LW'(1) << (int'(p) + POS_MAX);
    endfunction
    // opposing simultaneous pulls cancel out
    always_comb npos = (lpush ^ rpush) ? (rpush ? pos + PW'(1) : pos - PW'(1)) : pos;
    always_ff @(posedge clk) begin
        lwinrnd <= 1'b0;
        rwinrnd <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            leds       <= CENTRE;
            lscore     <= '0;
            rscore     <= '0;
            playing    <= 1'b0;
            match_over <= 1'b0;
            hold       <= '0;
        end else begin
            case (state)
                IDLE: if (refpush) begin
                    state   <= PLAY;
                    playing <= 1'b1;
                    pos     <= '0;
                    leds    <= CENTRE;
                end
                PLAY: begin
                    pos  <= npos;
                    leds <= marker(npos);
                    if (npos == -PMAX || npos == PMAX) begin
                        state   <= ROUND_END;
                        playing <= 1'b0;
                        hold    <= '0;
                    end
                    if (npos == -PMAX) begin
                        lscore  <= lscore + SCORE_W'(1);
                        lwinrnd <= 1'b1;
                    end
                    if (npos == PMAX) begin
                        rscore  <= rscore + SCORE_W'(1);
                        rwinrnd <= 1'b1;
                    end
                end
                ROUND_END: begin
                    hold <= hold + HW'(1);
                    if (hold == HW'(HOLD_CYCLES - 1)) begin
                        hold <= '0;
                        if (lscore == SCORE_W'(WIN_ROUNDS) || rscore == SCORE_W'(WIN_ROUNDS)) begin
                            state      <= MATCH_OVER;
                            match_over <= 1'b1;
                        end else begin
                            state <= IDLE;
                            pos   <= '0;
                            leds  <= CENTRE;
                        end
                    end
                end
                MATCH_OVER: if (refpush) begin
                    state      <= IDLE;
                    match_over <= 1'b0;
                    lscore     <= '0;
                    rscore     <= '0;
                    pos        <= '0;
                    leds       <= CENTRE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tug_rope_ctrl.sv
// tb_tug_rope_ctrl: scoreboard bench for tug_rope_ctrl against a game-rule reference model
module tb_tug_rope_ctrl;
    localparam int PM = 4, WR = 3, SW = 2, HC = 8;
    typedef struct packed {
        logic [2*PM:0] leds;
        logic [SW-1:0] ls, rs;
        logic lw, rw, pl, mo;
    } obs_t;
    logic clk = 0, rst = 1, lpush = 0, rpush = 0, refpush = 0;
    logic [2*PM:0] leds;
    logic [SW-1:0] lscore, rscore;
    logic lwinrnd, rwinrnd, playing, match_over;
    obs_t sb[$];
    int tests = 0, fails = 0;
    // model: phase 0 idle, 1 play, 2 round end, 3 match over
    int m_pos = 0, m_ls = 0, m_rs = 0, m_phase = 0, m_left = 0;
    bit m_lw, m_rw;
    tug_rope_ctrl #(.POS_MAX(PM), .WIN_ROUNDS(WR), .SCORE_W(SW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst), .lpush(lpush), .rpush(rpush), .refpush(refpush),
        .leds(leds), .lscore(lscore), .rscore(rscore), .lwinrnd(lwinrnd),
        .rwinrnd(rwinrnd), .playing(playing), .match_over(match_over)
    );
    always #5 clk = ~clk;
    function automatic obs_t model_step(input bit r, input bit l, input bit rp, input bit f);
        obs_t o;
        m_lw = 0;
        m_rw = 0;
        if (r) begin
            m_pos = 0; m_ls = 0; m_rs = 0; m_phase = 0; m_left = 0;
        end else if (m_phase == 0) begin
            if (f) begin m_phase = 1; m_pos = 0; end
        end else if (m_phase == 1) begin
            if (l && !rp) m_pos--;
            if (rp && !l) m_pos++;
            if (m_pos == -PM) begin m_ls++; m_lw = 1; m_phase = 2; m_left = HC; end
            if (m_pos == PM) begin m_rs++; m_rw = 1; m_phase = 2; m_left = HC; end
        end else if (m_phase == 2) begin
            m_left--;
            if (m_left == 0) begin
                if (m_ls == WR || m_rs == WR) m_phase = 3;
                else begin m_phase = 0; m_pos = 0; end
            end
        end else if (f) begin
            m_ls = 0; m_rs = 0; m_pos = 0; m_phase = 0;
        end
        o.leds = '0;
        o.leds[m_pos + PM] = 1'b1;
        o.ls = SW'(m_ls);
        o.rs = SW'(m_rs);
        o.lw = m_lw;
        o.rw = m_rw;
        o.pl = (m_phase == 1);
        o.mo = (m_phase == 3);
        return o;
    endfunction
    task automatic cyc(input bit r, input bit l, input bit rp, input bit f);
        @(negedge clk);
        rst = r; lpush = l; rpush = rp; refpush = f;
        sb.push_back(model_step(r, l, rp, f));
    endtask
    task automatic rep(input int n, input bit l, input bit rp);
        for (int i = 0; i < n; i++) cyc(0, l, rp, 0);
    endtask
    initial begin
        obs_t exp_o, got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_o = sb.pop_front();
                got = '{leds, lscore, rscore, lwinrnd, rwinrnd, playing, match_over};
                tests++;
                if (got !== exp_o) begin
                    fails++;
                    $display("FAIL outputs t=%0t got leds=%b ls=%0d rs=%0d lw=%b rw=%b pl=%b mo=%b required leds=%b ls=%0d rs=%0d lw=%b rw=%b pl=%b mo=%b",
                             $time, got.leds, got.ls, got.rs, got.lw, got.rw, got.pl, got.mo,
                             exp_o.leds, exp_o.ls, exp_o.rs, exp_o.lw, exp_o.rw, exp_o.pl, exp_o.mo);
                end
            end
        end
    end
    initial begin
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        rep(3, 1, 0);
        cyc(0, 1, 0, 1);
        rep(4, 0, 1);
        rep(4, 1, 0);
        rep(6, 0, 0);
        rep(5, 1, 1);
        rep(4, 1, 0);
        rep(8, 0, 1);
        rep(1, 0, 0);
        rep(2, 1, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1); rep(4, 1, 0); rep(8, 0, 0);
        end
        rep(3, 0, 1);
        cyc(0, 0, 0, 1);
        rep(2, 0, 0);
        cyc(0, 0, 0, 1); rep(3, 0, 1); rep(7, 1, 0); rep(9, 0, 0);
        cyc(0, 0, 0, 1); rep(4, 0, 1); rep(8, 0, 0);
        cyc(0, 0, 0, 1); rep(2, 0, 1);
        cyc(1, 0, 1, 0);
        rep(4, 0, 1);
        cyc(0, 0, 0, 1); rep(2, 1, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain %0d expected outputs left unchecked, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
